msg_loader: RTL

MSG_LOADER -- requirements
Module: msg_loader

---
 rtl/scroll_pkg.sv | 14 +
 rtl/nibble_packer.sv | 58 +++++
 rtl/msg_loader.sv | 114 +++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// Types and constants shared by the message loader and the scroll reader.
package scroll_pkg;

    localparam int unsigned NIB_PER_WORD = 4;
    localparam int unsigned WORD_W       = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StWrite,
        StDone
    } load_state_e;

endpackage

// File: rtl/nibble_packer.sv
// Packs accepted hex nibbles into a 16-bit word, first nibble in bits [3:0],
// padding nibbles not yet received, and counts nibbles for the whole load.
module nibble_packer
    import scroll_pkg::*;
#(
    parameter int unsigned CNT_W = 7,
    parameter logic [3:0]  PAD   = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [3:0]        i_digit,
    input  logic              i_last,
    output logic [WORD_W-1:0] o_word,
    output logic              o_last_nib,
    output logic [CNT_W-1:0]  o_count
);

    logic [1:0]        r_idx;
    logic [WORD_W-1:0] r_pack;
    logic [CNT_W-1:0]  r_count;

    // Word as it would look with i_digit inserted at the current index.
    always_comb begin
        o_word = '0;
        for (int i = 0; i < NIB_PER_WORD; i++) begin
            if (i < int'(r_idx)) begin
                o_word[4*i +: 4] = r_pack[4*i +: 4];
            end else if (i == int'(r_idx)) begin
                o_word[4*i +: 4] = i_digit;
            end else begin
                o_word[4*i +: 4] = PAD;
            end
        end
    end

    assign o_last_nib = (r_idx == 2'd3);
    assign o_count    = r_count;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_idx   <= '0;
            r_pack  <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_count <= r_count + CNT_W'(1);
            if (o_last_nib || i_last) begin
                r_idx  <= '0;
                r_pack <= '0;
            end else begin
                r_idx  <= r_idx + 2'd1;
                r_pack <= o_word;
            end
        end
    end

endmodule

// File: rtl/msg_loader.sv
// Loads a stream of hex digits into BRAM port A, four nibbles per word,
// and reports the stored nibble count when the message ends or the buffer fills.
module msg_loader
    import scroll_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter logic [3:0]  PAD    = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        digit,
    input  logic              digit_valid,
    input  logic              digit_last,
    output logic              digit_ready,
    output logic [ADDR_W-1:0] addra,
    output logic [WORD_W-1:0] data_in,
    output logic              ena,
    output logic              write_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W+2:0] msg_len
);

    localparam int unsigned CNT_W = ADDR_W + 3;

    load_state_e       r_state;
    logic              r_last;
    logic              w_xfer;
    logic              w_word_end;
    logic              w_clear;
    logic              w_last_nib;
    logic [WORD_W-1:0] w_word;
    logic [CNT_W-1:0]  w_count;

    assign w_xfer     = digit_valid && digit_ready && (r_state == StAccept);
    assign w_word_end = w_xfer && (w_last_nib || digit_last);
    assign w_clear    = (r_state == StIdle) && start;

    nibble_packer #(
        .CNT_W (CNT_W),
        .PAD   (PAD)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_push     (w_xfer),
        .i_digit    (digit),
        .i_last     (digit_last),
        .o_word     (w_word),
        .o_last_nib (w_last_nib),
        .o_count    (w_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_last      <= 1'b0;
            digit_ready <= 1'b0;
            addra       <= '0;
            data_in     <= '0;
            ena         <= 1'b0;
            write_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            msg_len     <= '0;
        end else begin
            done     <= 1'b0;
            write_en <= 1'b0;
            ena      <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state     <= StAccept;
                        r_last      <= 1'b0;
                        addra       <= '0;
                        digit_ready <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                StAccept: begin
                    if (w_word_end) begin
                        r_state     <= StWrite;
                        r_last      <= digit_last;
                        digit_ready <= 1'b0;
                        data_in     <= w_word;
                        write_en    <= 1'b1;
                        ena         <= 1'b1;
                    end
                end
                StWrite: begin
                    // A full buffer ends the message just like digit_last.
                    if (r_last || (addra == '1)) begin
                        r_state <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        msg_len <= w_count;
                    end else begin
                        r_state     <= StAccept;
                        addra       <= addra + ADDR_W'(1);
                        digit_ready <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
